// File: rtl/fft_result_sink_pkg.sv
// Shared types, widths and the power scaling helper for the FFT result sink.
// DATA_W and POW_W are fixed here so that every file agrees on the datapath widths.
package fft_sink_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int NFFT_DEF = 512;
  localparam int DATA_W   = 32;
  localparam int POW_W    = 32;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int FULL_W   = 2 * DATA_W + 1;

  // Scale the full-precision power down, clamping to all-ones when the
  // shifted value does not fit in the stored width.
  function automatic logic [POW_W-1:0] sat_shift(input logic [FULL_W-1:0] full,
                                                 input int unsigned     shift);
    logic [FULL_W-1:0] shifted;
    shifted = full >> shift;
    if (|shifted[FULL_W-1:POW_W]) return '1;
    return shifted[POW_W-1:0];
  endfunction

endpackage

// File: rtl/fft_result_sink_if.sv
// AXI4-Stream channel carrying FFT output bins ({im, re} plus XK_INDEX in tuser).
interface fft_result_sink_if;
  import fft_sink_pkg::*;

  logic [2*DATA_W-1:0] tdata;
  logic [15:0]         tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, output tuser, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tuser, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/fft_result_sink_ram.sv
// Simple dual-port power buffer: one write port, one registered read port.
module fft_pow_ram #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; only the read register resets.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_result_sink.sv
// Captures one FFT frame as scaled power per bin, tracks the peak bin and framing
// errors, and holds the finished frame for a reader until frame_ack.
module fft_result_sink
  import fft_sink_pkg::*;
#(
  parameter  int NFFT  = NFFT_DEF,
  parameter  int SHIFT = 32,
  localparam int IDX_W = $clog2(NFFT)
) (
  input  logic               clk,
  input  logic               rst,
  fft_result_sink_if.slave   s_axis,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [POW_W-1:0]   rd_data,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic [IDX_W-1:0]   peak_bin,
  output logic [POW_W-1:0]   peak_pow,
  output logic               err_tlast_early,
  output logic               err_tlast_miss,
  output logic               err_index
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NFFT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   bin_q, bin_d;
  logic               tready_q, tready_d;
  logic               frame_valid_q, frame_valid_d;
  logic [IDX_W-1:0]   peak_bin_q, peak_bin_d;
  logic [POW_W-1:0]   peak_pow_q, peak_pow_d;
  logic               err_early_q, err_early_d;
  logic               err_miss_q, err_miss_d;
  logic               err_index_q, err_index_d;
  logic               s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]   s1_bin_q, s1_bin_d;
  logic [PROD_W-1:0]  p_re_q, p_re_d;
  logic [PROD_W-1:0]  p_im_q, p_im_d;
  logic               s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]   s2_bin_q, s2_bin_d;
  logic [POW_W-1:0]   pow_q, pow_d;

  logic signed [DATA_W-1:0] re_s, im_s;
  logic                     beat, last_bin, final_beat;

  assign re_s = s_axis.tdata[DATA_W-1:0];
  assign im_s = s_axis.tdata[2*DATA_W-1:DATA_W];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    frame_valid_d = frame_valid_q;
    peak_bin_d    = peak_bin_q;
    peak_pow_d    = peak_pow_q;
    err_early_d   = err_early_q;
    err_miss_d    = err_miss_q;
    err_index_d   = err_index_q;

    // tready_q is only ever high in CAPTURE, so it alone qualifies a beat.
    beat       = s_axis.tvalid && tready_q;
    last_bin   = (bin_q == LAST_BIN);
    final_beat = beat && (s_axis.tlast || last_bin);

    s1_vld_d = beat;
    s1_bin_d = bin_q;
    p_re_d   = PROD_W'(re_s) * PROD_W'(re_s);
    p_im_d   = PROD_W'(im_s) * PROD_W'(im_s);

    s2_vld_d = s1_vld_q;
    s2_bin_d = s1_bin_q;
    pow_d    = sat_shift({1'b0, p_re_q} + {1'b0, p_im_q}, SHIFT);

    // Bin 0 loads unconditionally so a previous frame's peak can never survive.
    if (s2_vld_q && (s2_bin_q == '0 || pow_q > peak_pow_q)) begin
      peak_bin_d = s2_bin_q;
      peak_pow_d = pow_q;
    end

    if (beat) begin
      if (s_axis.tuser[IDX_W-1:0] != bin_q) err_index_d = 1'b1;
      if (s_axis.tlast && !last_bin)        err_early_d = 1'b1;
      if (last_bin && !s_axis.tlast)        err_miss_d  = 1'b1;
    end

    unique case (state_q)
      CAPTURE: begin
        if (beat) bin_d = final_beat ? '0 : bin_q + 1'b1;
        if (final_beat) state_d = DRAIN;
      end
      // The last write lands in S3 on the same edge that enters HOLD.
      DRAIN: begin
        if (!s1_vld_q) begin
          state_d       = HOLD;
          frame_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d       = CAPTURE;
          frame_valid_d = 1'b0;
          peak_bin_d    = '0;
          peak_pow_d    = '0;
          bin_d         = '0;
        end
      end
      default: state_d = CAPTURE;
    endcase

    tready_d = (state_d == CAPTURE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= CAPTURE;
      bin_q         <= '0;
      tready_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      peak_bin_q    <= '0;
      peak_pow_q    <= '0;
      err_early_q   <= 1'b0;
      err_miss_q    <= 1'b0;
      err_index_q   <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_bin_q      <= '0;
      p_re_q        <= '0;
      p_im_q        <= '0;
      s2_vld_q      <= 1'b0;
      s2_bin_q      <= '0;
      pow_q         <= '0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      tready_q      <= tready_d;
      frame_valid_q <= frame_valid_d;
      peak_bin_q    <= peak_bin_d;
      peak_pow_q    <= peak_pow_d;
      err_early_q   <= err_early_d;
      err_miss_q    <= err_miss_d;
      err_index_q   <= err_index_d;
      s1_vld_q      <= s1_vld_d;
      s1_bin_q      <= s1_bin_d;
      p_re_q        <= p_re_d;
      p_im_q        <= p_im_d;
      s2_vld_q      <= s2_vld_d;
      s2_bin_q      <= s2_bin_d;
      pow_q         <= pow_d;
    end
  end

  fft_pow_ram #(
    .DEPTH (NFFT),
    .WIDTH (POW_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (s2_vld_q),
    .waddr (s2_bin_q),
    .wdata (pow_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign s_axis.tready   = tready_q;
  assign frame_valid     = frame_valid_q;
  assign peak_bin        = peak_bin_q;
  assign peak_pow        = peak_pow_q;
  assign err_tlast_early = err_early_q;
  assign err_tlast_miss  = err_miss_q;
  assign err_index       = err_index_q;

endmodule

// File: tb/tb_fft_result_sink.sv
// Drives two sinks (SHIFT=0 and SHIFT=32) with identical streams and checks them
// against an arithmetic frame model.
module tb_fft_result_sink;
  import fft_sink_pkg::*;

  localparam int NFFT  = 8;
  localparam int IDX_W = 3;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [15:0] tuser;
    logic        tlast;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_result_sink_if s_if ();
  fft_result_sink_if s32_if ();
  assign s32_if.tdata  = s_if.tdata;
  assign s32_if.tuser  = s_if.tuser;
  assign s32_if.tvalid = s_if.tvalid;
  assign s32_if.tlast  = s_if.tlast;

  logic [IDX_W-1:0] rd_addr;
  logic             frame_ack;
  logic [31:0]      rd0, rd32, pp0, pp32;
  logic [IDX_W-1:0] pb0, pb32;
  logic             fv0, fv32;
  logic             ee0, em0, ei0, ee32, em32, ei32;

  fft_result_sink #(.NFFT(NFFT), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .s_axis(s_if.slave), .rd_addr(rd_addr), .rd_data(rd0),
    .frame_valid(fv0), .frame_ack(frame_ack), .peak_bin(pb0), .peak_pow(pp0),
    .err_tlast_early(ee0), .err_tlast_miss(em0), .err_index(ei0)
  );

  fft_result_sink #(.NFFT(NFFT), .SHIFT(32)) u_dut32 (
    .clk(clk), .rst(rst), .s_axis(s32_if.slave), .rd_addr(rd_addr), .rd_data(rd32),
    .frame_valid(fv32), .frame_ack(frame_ack), .peak_bin(pb32), .peak_pow(pp32),
    .err_tlast_early(ee32), .err_tlast_miss(em32), .err_index(ei32)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state; index 0 is SHIFT=0, index 1 is SHIFT=32.
  beat_t            frame_q[$];
  logic [31:0]      exp_mem [2][NFFT];
  bit               known [NFFT];
  bit               m_early, m_miss, m_idx;
  logic [IDX_W-1:0] m_pbin [2];
  logic [31:0]      m_ppow [2];

  function automatic logic [31:0] model_pow(logic [31:0] re, logic [31:0] im, int sh);
    longint     sre, sim;
    logic [64:0] s;
    sre = longint'(signed'(re));
    sim = longint'(signed'(im));
    s = 65'(sre * sre) + 65'(sim * sim);
    s = s >> sh;
    if (s > 65'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    v = $urandom() >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic apply_frame();
    int          idx;
    logic [31:0] p;
    idx = 0;
    foreach (frame_q[j]) begin
      for (int k = 0; k < 2; k++) begin
        p = model_pow(frame_q[j].re, frame_q[j].im, (k == 0) ? 0 : 32);
        exp_mem[k][idx] = p;
        if (idx == 0 || p > m_ppow[k]) begin
          m_pbin[k] = IDX_W'(idx);
          m_ppow[k] = p;
        end
      end
      known[idx] = 1'b1;
      if (frame_q[j].tuser != 16'(idx))          m_idx   = 1'b1;
      if (frame_q[j].tlast && idx != NFFT - 1)   m_early = 1'b1;
      if (idx == NFFT - 1 && !frame_q[j].tlast)  m_miss  = 1'b1;
      idx++;
    end
  endtask

  task automatic push_beat(logic [31:0] re, logic [31:0] im, int tuser, bit tlast);
    beat_t b;
    b.re = re; b.im = im; b.tuser = 16'(tuser); b.tlast = tlast;
    frame_q.push_back(b);
  endtask

  task automatic build_random(int n, bit with_tlast);
    frame_q.delete();
    for (int i = 0; i < n; i++) push_beat(rand_val(), rand_val(), i, with_tlast && (i == n - 1));
  endtask

  // Returns at the negedge before the edge that accepts the final beat.
  task automatic send_frame(int valid_pct);
    int i = 0;
    int guard = 0;
    bit pend = 0;
    while (i < frame_q.size()) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: got %0d beats accepted, required %0d", i, frame_q.size());
        return;
      end
      if (!pend) begin
        if ($urandom_range(0, 99) < valid_pct) begin
          s_if.tdata  = {frame_q[i].im, frame_q[i].re};
          s_if.tuser  = frame_q[i].tuser;
          s_if.tlast  = frame_q[i].tlast;
          s_if.tvalid = 1'b1;
          pend = 1;
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      if (pend && s_if.tready) begin
        i++;
        pend = 0;
      end
    end
  endtask

  task automatic check_frame(string name, bit hold_valid);
    int n = 0;
    @(negedge clk);
    if (!hold_valid) s_if.tvalid = 1'b0;
    forever begin
      checks++;
      if (s_if.tready !== 1'b0) begin
        errors++;
        $display("FAIL %s tready_after_last: got %b required 0", name, s_if.tready);
      end
      if (fv0 === 1'b1) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL %s frame_valid_timeout: got 0 required 1", name);
        return;
      end
      @(negedge clk);
    end
    checks += 7;
    if (fv32 !== 1'b1)        begin errors++; $display("FAIL %s fv32: got %b required 1", name, fv32); end
    if (pb0 !== m_pbin[0])    begin errors++; $display("FAIL %s peak_bin: got %0d required %0d", name, pb0, m_pbin[0]); end
    if (pp0 !== m_ppow[0])    begin errors++; $display("FAIL %s peak_pow: got %h required %h", name, pp0, m_ppow[0]); end
    if (pb32 !== m_pbin[1])   begin errors++; $display("FAIL %s peak_bin32: got %0d required %0d", name, pb32, m_pbin[1]); end
    if (pp32 !== m_ppow[1])   begin errors++; $display("FAIL %s peak_pow32: got %h required %h", name, pp32, m_ppow[1]); end
    if ({ee0, em0, ei0} !== {m_early, m_miss, m_idx})
      begin errors++; $display("FAIL %s errs: got %b required %b", name, {ee0, em0, ei0}, {m_early, m_miss, m_idx}); end
    if ({ee32, em32, ei32} !== {m_early, m_miss, m_idx})
      begin errors++; $display("FAIL %s errs32: got %b required %b", name, {ee32, em32, ei32}, {m_early, m_miss, m_idx}); end
    for (int i = 0; i < NFFT; i++) begin
      if (!known[i]) continue;
      @(negedge clk);
      rd_addr = IDX_W'(i);
      @(negedge clk);
      checks += 3;
      if (rd0 !== exp_mem[0][i])  begin errors++; $display("FAIL %s rd_data[%0d]: got %h required %h", name, i, rd0, exp_mem[0][i]); end
      if (rd32 !== exp_mem[1][i]) begin errors++; $display("FAIL %s rd_data32[%0d]: got %h required %h", name, i, rd32, exp_mem[1][i]); end
      if (s_if.tready !== 1'b0)   begin errors++; $display("FAIL %s tready_hold: got %b required 0", name, s_if.tready); end
    end
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack   = 1'b0;
    s_if.tvalid = 1'b0;
    checks += 2;
    if ({fv0, pb0, pp0} !== '0) begin errors++; $display("FAIL %s ack_clear: got fv=%b pb=%0d pp=%h required all 0", name, fv0, pb0, pp0); end
    if (s_if.tready !== 1'b1)   begin errors++; $display("FAIL %s tready_after_ack: got %b required 1", name, s_if.tready); end
  endtask

  task automatic check_all_zero(string name);
    checks += 4;
    if ({fv0, fv32, s_if.tready, s32_if.tready} !== '0)
      begin errors++; $display("FAIL %s valid_ready: got %b required 0", name, {fv0, fv32, s_if.tready, s32_if.tready}); end
    if ({pb0, pp0, pb32, pp32} !== '0)
      begin errors++; $display("FAIL %s peak: got pb=%0d pp=%h pb32=%0d pp32=%h required 0", name, pb0, pp0, pb32, pp32); end
    if ({ee0, em0, ei0, ee32, em32, ei32} !== '0)
      begin errors++; $display("FAIL %s errs: got %b required 0", name, {ee0, em0, ei0, ee32, em32, ei32}); end
    if ({rd0, rd32} !== '0)
      begin errors++; $display("FAIL %s rd_data: got %h/%h required 0", name, rd0, rd32); end
  endtask

  task automatic model_reset();
    foreach (known[i]) known[i] = 1'b0;
    m_early = 0; m_miss = 0; m_idx = 0;
    m_pbin = '{default: '0};
    m_ppow = '{default: '0};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_if.tdata = '0; s_if.tuser = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    rd_addr = '0; frame_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
  endtask

  task automatic test_basic();
    frame_q.delete();
    for (int i = 0; i < NFFT; i++)
      push_beat((i == 5) ? 32'd3 : 32'd0, (i == 5) ? 32'd4 : 32'd0, i, i == NFFT - 1);
    apply_frame();
    send_frame(100);
    check_frame("basic", 0);
  endtask

  task automatic test_saturation();
    frame_q.delete();
    for (int i = 0; i < NFFT; i++) begin
      if (i == 2)      push_beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, i, 0);
      else if (i == 3) push_beat(32'h8000_0000, 32'h8000_0000, i, 0);
      else             push_beat(32'd0, 32'd0, i, i == NFFT - 1);
    end
    apply_frame();
    send_frame(100);
    check_frame("saturation", 0);
  endtask

  task automatic test_back_to_back();
    build_random(NFFT, 1);
    apply_frame();
    send_frame(50);
    check_frame("b2b_frame1", 1);
    build_random(NFFT, 1);
    apply_frame();
    send_frame(50);
    check_frame("b2b_frame2", 1);
  endtask

  task automatic test_peak_tie();
    frame_q.delete();
    for (int i = 0; i < NFFT; i++) begin
      if (i == 1)      push_beat(32'd3, 32'd0, i, 0);
      else if (i == 6) push_beat(32'd0, 32'hFFFF_FFFD, i, 0);
      else             push_beat(32'd1, 32'd1, i, i == NFFT - 1);
    end
    apply_frame();
    send_frame(70);
    check_frame("peak_tie", 0);
  endtask

  task automatic test_index();
    build_random(NFFT, 1);
    frame_q[0].tuser = 16'd3;
    apply_frame();
    send_frame(100);
    check_frame("index", 0);
  endtask

  task automatic test_tlast_early();
    build_random(5, 1);
    apply_frame();
    send_frame(80);
    check_frame("tlast_early", 0);
  endtask

  task automatic test_tlast_miss();
    build_random(NFFT, 0);
    apply_frame();
    send_frame(80);
    check_frame("tlast_miss", 0);
  endtask

  task automatic test_reset_midframe();
    frame_q.delete();
    for (int i = 0; i < 4; i++) push_beat(32'h0001_0000, 32'h0001_0000, i, 0);
    send_frame(100);
    @(negedge clk);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    #1;
    check_all_zero("reset_midframe");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    build_random(NFFT, 1);
    apply_frame();
    send_frame(60);
    check_frame("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_peak_tie();
    test_index();
    test_tlast_early();
    test_tlast_miss();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
